exc_ctrl: RTL
=============

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, 32'h00000020, handler entry address for all non-eret exceptions.
REQ-002 Parameter DRAIN_CYCLES, 2, refill cycles after a flush during which new exceptions are ignored; legal range 1..15.
REQ-003 Parameter STALL_LIMIT, 16'd1024, consecutive stall cycles that trip the watchdog.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 stallreq_id_i  in  1  decode-stage stall request.
REQ-007 stallreq_ex_i  in  1  execute-stage stall request (multi-cycle ops).
REQ-008 stallreq_mem_i  in  1  memory-stage stall request (bus wait).
REQ-009 excepttype_i  in  32  mem-stage exception code: 0x1 int, 0x8 syscall, 0xa invalid inst, 0xc ov, 0xd trap, 0xe eret, 0 none.
REQ-010 cp0_epc_i  in  32  current EPC value, already forwarded.
REQ-011 stall_o  out  6  stall vector {wb,mem,ex,id,if,pc}, bit0 = pc.
REQ-012 flush_o  out  1  pipeline flush pulse.
REQ-013 new_pc_o  out  32  redirect target, valid while flush_o = 1.
REQ-014 exc_count_o  out  16  count of accepted exceptions, saturating.
REQ-015 stall_timeout_o  out  1  sticky watchdog flag.

Function
REQ-016 The FSM SHALL have three states: RUN, FLUSH, DRAIN.
REQ-017 In RUN, a recognised non-zero excepttype_i SHALL cause the next state to be FLUSH; unrecognised codes SHALL be treated as 0.
REQ-018 FLUSH SHALL last exactly one cycle, with flush_o = 1 and new_pc_o valid; the next state is DRAIN.
REQ-019 new_pc_o SHALL be registered on acceptance: cp0_epc_i for 0xe, EXC_VECTOR for all other recognised codes; latency from excepttype_i to flush_o is 1 cycle.
REQ-020 DRAIN SHALL last DRAIN_CYCLES cycles, counted by a 4-bit down-counter; excepttype_i is ignored and is not counted; the state returns to RUN when the counter reaches 0.
REQ-021 Stall priority SHALL be mem > ex > id: mem gives 6'b011111, ex gives 6'b001111, id gives 6'b000111, none gives 6'b000000.
REQ-022 stall_o SHALL be combinational from the stall requests and the state; it is forced to 0 in any cycle where an exception is accepted and in FLUSH.
REQ-023 In DRAIN, stall_o SHALL follow the requests normally.
REQ-024 exc_count_o SHALL increment by 1 per accepted exception, eret included, and hold at 16'hFFFF.
REQ-025 flush_o SHALL be 0 and new_pc_o SHALL hold its last value in RUN and DRAIN.
REQ-026 When an exception and any stall request occur in the same RUN cycle, the exception SHALL win and the stall SHALL be dropped for that cycle.

Reset
REQ-027 With rst = 1 at a clock edge: state = RUN, flush_o = 0, new_pc_o = 0, exc_count_o = 0, drain counter = 0, watchdog counter = 0, stall_timeout_o = 0.
REQ-028 Reset SHALL take priority over every event, including reset asserted during FLUSH or DRAIN, which SHALL return the FSM to RUN with no flush pulse.
REQ-029 stall_o SHALL be 0 while rst = 1.

Configuration
REQ-030 Macro EXC_CTRL_WATCHDOG_EN defined: a 16-bit counter SHALL increment on each cycle with stall_o != 0 and clear on each cycle with stall_o = 0.
REQ-031 With the macro defined, stall_timeout_o SHALL set when the count reaches STALL_LIMIT and stay set until reset; the counter SHALL saturate at STALL_LIMIT.
REQ-032 Macro EXC_CTRL_WATCHDOG_EN undefined: the counter SHALL be absent and stall_timeout_o SHALL be tied to 0.

Verification
REQ-033 excepttype_i = 0x8 for one cycle in RUN -> the next cycle has flush_o = 1, new_pc_o = 0x20, exc_count_o = 1; then 2 DRAIN cycles; then RUN.
REQ-034 excepttype_i = 0xe with cp0_epc_i = 0x1000 -> flush_o = 1 one cycle later with new_pc_o = 0x1000.
REQ-035 stallreq_mem_i = 1 and stallreq_id_i = 1 -> stall_o = 6'b011111; in the same cycle excepttype_i = 0xc -> stall_o = 0, and the flush follows.
REQ-036 excepttype_i = 0x1 asserted during DRAIN -> no flush and exc_count_o unchanged; rst pulsed during FLUSH -> flush_o = 0 on the next cycle and state = RUN.
REQ-037 With the macro defined, STALL_LIMIT = 4 and stallreq_ex_i held high for 5 cycles -> stall_timeout_o = 1 and stays 1 after the stall releases; with the macro undefined -> stall_timeout_o stays 0.
REQ-038 65537 accepted exceptions -> exc_count_o = 16'hFFFF.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception/stall controller: stall priority, one-cycle flush with redirect PC, and post-flush drain.
// Optional stall watchdog is built when EXC_CTRL_WATCHDOG_EN is defined.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [15:0] STALL_LIMIT  = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [15:0] exc_count_o,
  output logic        stall_timeout_o
);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [15:0] exc_count_q, exc_count_d;
  logic        recognised;
  logic        accept;

  always_comb begin
    case (excepttype_i)
      32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he: recognised = 1'b1;
      default:                                  recognised = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    new_pc_d    = new_pc_q;
    exc_count_d = exc_count_q;
    accept      = 1'b0;
    flush_o     = 1'b0;
    stall_o     = 6'b000000;
    case (state_q)
      RUN: begin
        if (recognised) begin
          accept   = 1'b1;
          state_d  = FLUSH;
          new_pc_d = (excepttype_i == 32'he) ? cp0_epc_i : EXC_VECTOR;
          if (exc_count_q != 16'hFFFF) exc_count_d = exc_count_q + 16'd1;
        end
      end
      FLUSH: begin
        flush_o     = 1'b1;
        state_d     = DRAIN;
        drain_cnt_d = 4'(DRAIN_CYCLES);
      end
      DRAIN: begin
        // Exceptions arriving here belong to squashed instructions and are dropped.
        drain_cnt_d = drain_cnt_q - 4'd1;
        if (drain_cnt_q <= 4'd1) begin
          drain_cnt_d = 4'd0;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // An accepted exception outranks any stall in the same cycle.
    if (!rst && !accept && state_q != FLUSH) begin
      if (stallreq_mem_i)     stall_o = 6'b011111;
      else if (stallreq_ex_i) stall_o = 6'b001111;
      else if (stallreq_id_i) stall_o = 6'b000111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drain_cnt_q <= 4'd0;
      new_pc_q    <= 32'd0;
      exc_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      new_pc_q    <= new_pc_d;
      exc_count_q <= exc_count_d;
    end
  end

  assign new_pc_o    = new_pc_q;
  assign exc_count_o = exc_count_q;

`ifdef EXC_CTRL_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    wd_cnt_d = 16'd0;
    if (stall_o != 6'b000000) begin
      wd_cnt_d = (wd_cnt_q >= STALL_LIMIT) ? STALL_LIMIT : wd_cnt_q + 16'd1;
    end
    timeout_d = timeout_q | (wd_cnt_d == STALL_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_timeout_o = timeout_q;
`else
  assign stall_timeout_o = 1'b0 & (STALL_LIMIT == 16'd0);
`endif

endmodule
